// File: rtl/pmp_csr_file.sv
// pmp_csr_file: RV32 PMP CSRs (pmpcfg0, pmpaddr0..3) with lock, TOR-lock and WARL legalisation,
// feeding per-entry cfg/addr to the combinational PMP checker.
module pmp_csr_file #(
  parameter int          NUM_ENTRIES = 4,
  parameter logic [11:0] CFG_BASE    = 12'h3A0,
  parameter logic [11:0] ADDR_BASE   = 12'h3B0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      csr_en,
  input  logic [1:0]                csr_op,
  input  logic [11:0]               csr_addr,
  input  logic [31:0]               csr_wdata,
  input  logic [1:0]                csr_priv,
  output logic                      csr_rvalid,
  output logic [31:0]               csr_rdata,
  output logic                      csr_illegal,
  output logic [8*NUM_ENTRIES-1:0]  pmp_cfg,
  output logic [32*NUM_ENTRIES-1:0] pmp_addr,
  output logic                      pmp_update
);
  logic [NUM_ENTRIES-1:0][7:0]  r_cfg, w_cfg_nxt;
  logic [NUM_ENTRIES-1:0][31:0] r_addr, w_addr_nxt;
  logic [NUM_ENTRIES-1:0]       w_lk, w_tor, w_addr_blk;
  logic [11:0]                  w_off;
  logic                         w_hit_cfg, w_hit_addr, w_legal, w_wr;
  logic [31:0]                  w_old, w_new;

  assign w_off      = csr_addr - ADDR_BASE;
  assign w_hit_cfg  = csr_addr == CFG_BASE;
  assign w_hit_addr = csr_addr >= ADDR_BASE && w_off < 12'(NUM_ENTRIES);
  assign w_legal    = csr_en && (w_hit_cfg || w_hit_addr) && csr_priv == 2'b11;
  assign w_wr       = w_legal && csr_op != 2'd0;
  assign w_old      = w_hit_cfg ? r_cfg : r_addr[w_off[1:0]];
  assign w_new      = csr_op == 2'd1 ? csr_wdata :
                      csr_op == 2'd2 ? (w_old | csr_wdata) : (w_old & ~csr_wdata);

  // pmpaddr i is frozen by its own lock or by a locked TOR entry i+1 using it as base
  always_comb begin
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      w_lk[k]  = r_cfg[k][7];
      w_tor[k] = r_cfg[k][7] && r_cfg[k][4:3] == 2'b01;
    end
  end
  assign w_addr_blk = w_lk | (w_tor >> 1);

  always_comb begin
    w_cfg_nxt  = r_cfg;
    w_addr_nxt = r_addr;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (w_wr && w_hit_cfg && !w_lk[k])
        w_cfg_nxt[k] = {w_new[8*k+7], 2'b00, w_new[8*k+4 -: 3], w_new[8*k+1] & w_new[8*k], w_new[8*k]};
      if (w_wr && w_hit_addr && w_off == 12'(k) && !w_addr_blk[k])
        w_addr_nxt[k] = w_new;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg       <= '0;
      r_addr      <= '0;
      csr_rvalid  <= 1'b0;
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
      pmp_update  <= 1'b0;
    end else begin
      r_cfg       <= w_cfg_nxt;
      r_addr      <= w_addr_nxt;
      csr_rvalid  <= csr_en;
      csr_rdata   <= w_legal ? w_old : 32'd0;
      csr_illegal <= csr_en && !w_legal;
      pmp_update  <= {w_cfg_nxt, w_addr_nxt} != {r_cfg, r_addr};
    end
  end

  assign pmp_cfg  = r_cfg;
  assign pmp_addr = r_addr;
endmodule

// File: tb/tb_pmp_csr_file.sv
// tb_pmp_csr_file: directed checks of pmp_csr_file access, legalisation, locking and reset.
module tb_pmp_csr_file;
  logic         clock = 1'b0, reset_n = 1'b0, csr_en = 1'b0;
  logic [1:0]   csr_op = '0, csr_priv = 2'b11;
  logic [11:0]  csr_addr = '0;
  logic [31:0]  csr_wdata = '0;
  logic         csr_rvalid, csr_illegal, pmp_update;
  logic [31:0]  csr_rdata;
  logic [31:0]  pmp_cfg;
  logic [127:0] pmp_addr;
  int n_chk = 0, n_fail = 0;

  pmp_csr_file dut (
    .clock(clock), .reset_n(reset_n), .csr_en(csr_en), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_priv(csr_priv),
    .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .pmp_cfg(pmp_cfg), .pmp_addr(pmp_addr), .pmp_update(pmp_update)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d, input logic [1:0] p);
    @(negedge clock);
    csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d; csr_priv = p;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    @(negedge clock);
    csr_en = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic resp(input string tag, input logic [31:0] rd, input logic ill, input logic upd);
    chk({tag, "_rvalid"}, 128'(csr_rvalid), 128'(1'b1));
    chk({tag, "_rdata"}, 128'(csr_rdata), 128'(rd));
    chk({tag, "_illegal"}, 128'(csr_illegal), 128'(ill));
    chk({tag, "_update"}, 128'(pmp_update), 128'(upd));
  endtask

  initial begin
    #12;
    chk("rst_rvalid", 128'(csr_rvalid), 128'(0));
    chk("rst_update", 128'(pmp_update), 128'(0));
    chk("rst_cfg", 128'(pmp_cfg), 128'(0));
    chk("rst_addr", pmp_addr, 128'(0));
    @(negedge clock); reset_n = 1'b1;

    acc(2'd0, 12'h3A0, 32'hFFFF_FFFF, 2'b11); resp("rd_cfg", 32'h0, 1'b0, 1'b0);
    acc(2'd0, 12'h3B2, 32'h0, 2'b11);         resp("rd_a2", 32'h0, 1'b0, 1'b0);
    chk("rd_cfg_state", 128'(pmp_cfg), 128'(0));

    acc(2'd1, 12'h3B1, 32'h2000_0000, 2'b11); resp("wr_a1", 32'h0, 1'b0, 1'b1);
    chk("wr_a1_val", 128'(pmp_addr[63:32]), 128'(32'h2000_0000));
    acc(2'd1, 12'h3A0, 32'h0000_0F00, 2'b11); resp("wr_cfg", 32'h0, 1'b0, 1'b1);
    chk("wr_cfg_val", 128'(pmp_cfg[15:8]), 128'(8'h0F));
    idle();
    chk("idle_rvalid", 128'(csr_rvalid), 128'(0));
    chk("idle_update", 128'(pmp_update), 128'(0));
    acc(2'd0, 12'h3A0, 32'h0, 2'b11); resp("rb_cfg", 32'h0000_0F00, 1'b0, 1'b0);

    acc(2'd1, 12'h3A0, 32'h0000_00E2, 2'b11); resp("warl", 32'h0000_0F00, 1'b0, 1'b1);
    chk("warl_val", 128'(pmp_cfg), 128'(32'h0000_0080));

    acc(2'd1, 12'h3A0, 32'h0000_8900, 2'b11); resp("lk1", 32'h0000_0080, 1'b0, 1'b1);
    chk("lk1_val", 128'(pmp_cfg), 128'(32'h0000_8980));
    acc(2'd1, 12'h3B0, 32'h5, 2'b11);          resp("lk_a0", 32'h0, 1'b0, 1'b0);
    acc(2'd1, 12'h3B1, 32'h7, 2'b11);          resp("lk_a1", 32'h2000_0000, 1'b0, 1'b0);
    acc(2'd3, 12'h3A0, 32'hFFFF_FFFF, 2'b11);  resp("lk_clr", 32'h0000_8980, 1'b0, 1'b0);
    chk("lk_cfg", 128'(pmp_cfg), 128'(32'h0000_8980));
    chk("lk_addr", pmp_addr, {64'h0, 32'h2000_0000, 32'h0});

    acc(2'd1, 12'h3A0, 32'hFFFF_FFFF, 2'b00);  resp("ill_priv", 32'h0, 1'b1, 1'b0);
    acc(2'd0, 12'h3B7, 32'h0, 2'b11);          resp("ill_3b7", 32'h0, 1'b1, 1'b0);
    acc(2'd1, 12'h3B4, 32'h1, 2'b11);          resp("ill_3b4", 32'h0, 1'b1, 1'b0);
    chk("ill_state", {pmp_addr[127:96], pmp_cfg}, {32'h0, 32'h0000_8980});

    acc(2'd1, 12'h3B3, 32'hDEAD_BEEF, 2'b11);  resp("wr_a3", 32'h0, 1'b0, 1'b1);
    chk("wr_a3_val", 128'(pmp_addr[127:96]), 128'(32'hDEAD_BEEF));
    #2; reset_n = 1'b0; csr_en = 1'b0;
    #1;
    chk("arst_rvalid", 128'(csr_rvalid), 128'(0));
    chk("arst_a3", 128'(pmp_addr[127:96]), 128'(0));
    chk("arst_all", {pmp_addr, pmp_cfg}, 160'(0));
    @(negedge clock); reset_n = 1'b1;

    acc(2'd1, 12'h3A0, 32'h8800_0000, 2'b11); resp("tor3", 32'h0, 1'b0, 1'b1);
    chk("tor3_val", 128'(pmp_cfg), 128'(32'h8800_0000));
    acc(2'd1, 12'h3B2, 32'h9, 2'b11);          resp("tor_a2", 32'h0, 1'b0, 1'b0);
    chk("tor_a2_val", 128'(pmp_addr[95:64]), 128'(0));
    acc(2'd1, 12'h3B1, 32'h3, 2'b11);          resp("a1_free", 32'h0, 1'b0, 1'b1);
    acc(2'd2, 12'h3B1, 32'h0, 2'b11);          resp("set0", 32'h3, 1'b0, 1'b0);
    acc(2'd2, 12'h3B1, 32'h4, 2'b11);          resp("set4", 32'h3, 1'b0, 1'b1);
    acc(2'd3, 12'h3B1, 32'h1, 2'b11);          resp("clr1", 32'h7, 1'b0, 1'b1);
    chk("clr1_val", 128'(pmp_addr[63:32]), 128'(32'h6));
    acc(2'd2, 12'h3A0, 32'h1000_0000, 2'b11); resp("set_lk3", 32'h8800_0000, 1'b0, 1'b0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
